// File: rtl/addsub_pipe.sv
// rtl/addsub_pipe.sv - two-stage pipelined add/sub/compare unit with valid/ready on both sides
// Stage 1 holds the operands feeding the CLA; stage 2 holds the result and flags of the raw sum.
module addsub_pipe #(
  parameter int TAG_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [31:0]      in_a,
  input  logic [31:0]      in_b,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_result,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_zero,
  output logic             out_neg,
  output logic             out_carry,
  output logic             out_ovf
);
  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SLT = 2'b10;

  logic             s1_valid;
  logic [1:0]       s1_op;
  logic [31:0]      s1_a;
  logic [31:0]      s1_b;
  logic [TAG_W-1:0] s1_tag;
  logic             s2_valid;

  logic        adv1, adv2, in_fire, s2_load;
  logic        is_sub;
  logic [31:0] b_eff, sum;
  logic        c_out, ovf, neg, cmp;

  assign adv2     = !s2_valid || out_ready;
  assign adv1     = !s1_valid || adv2;
  assign in_ready = rst_n && adv1 && !flush;
  assign in_fire  = in_valid && in_ready;
  assign s2_load  = s1_valid && adv2 && !flush;
  assign out_valid = s2_valid;

  // SUB, SLT and SLTU all compute a + ~b + 1
  assign is_sub = (s1_op != OP_ADD);
  assign b_eff  = is_sub ? ~s1_b : s1_b;

  cla_32bit u_cla (
    .a     (s1_a),
    .b     (b_eff),
    .c_in  (is_sub),
    .sum   (sum),
    .c_out (c_out)
  );

  assign neg = sum[31];
  assign ovf = (s1_a[31] == b_eff[31]) && (sum[31] != s1_a[31]);
  assign cmp = (s1_op == OP_SLT) ? (neg ^ ovf) : !c_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_op    <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      s1_tag   <= '0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_a     <= in_a;
      s1_b     <= in_b;
      s1_tag   <= in_tag;
    end else if (adv1) begin
      s1_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid   <= 1'b0;
      out_result <= '0;
      out_tag    <= '0;
      out_zero   <= 1'b0;
      out_neg    <= 1'b0;
      out_carry  <= 1'b0;
      out_ovf    <= 1'b0;
    end else if (flush) begin
      s2_valid <= 1'b0;
    end else if (adv2) begin
      s2_valid <= s1_valid;
      if (s2_load) begin
        out_result <= s1_op[1] ? {31'b0, cmp} : sum;
        out_tag    <= s1_tag;
        out_zero   <= (sum == 32'd0);
        out_neg    <= neg;
        out_carry  <= c_out;
        out_ovf    <= ovf;
      end
    end
  end
endmodule

// 32-bit carry-lookahead adder built from eight 4-bit lookahead groups
module cla_32bit (
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic        c_in,
  output logic [31:0] sum,
  output logic        c_out
);
  logic [31:0] g, p;

  assign g = a & b;
  assign p = a ^ b;

  always_comb begin
    logic [32:0] c;
    c    = '0;
    c[0] = c_in;
    for (int k = 0; k < 8; k++) begin
      c[4*k+1] = g[4*k] | (p[4*k] & c[4*k]);
      c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | ((&p[4*k +: 2]) & c[4*k]);
      c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | ((&p[4*k+1 +: 2]) & g[4*k])
               | ((&p[4*k +: 3]) & c[4*k]);
      c[4*k+4] = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | ((&p[4*k+2 +: 2]) & g[4*k+1])
               | ((&p[4*k+1 +: 3]) & g[4*k]) | ((&p[4*k +: 4]) & c[4*k]);
    end
    sum   = p ^ c[31:0];
    c_out = c[32];
  end
endmodule
